// File: rtl/conv_layer_input_interface.sv
// conv_layer_input_interface
// Command responder between the conv-layer controller, the pixel ROM and the
// kernel array. PRELOAD/LOAD fetch one image row from the ROM into a row
// buffer, SHIFT presents an ARRAY_SIZE-wide window and rotates the buffer left.
// Each command is answered by a one-cycle ack.
// Optional feature macro: CONV_IF_ERR_EN adds the sticky cmd_err output, set
// when a non-IDLE command arrives while a fetch is in progress.
module conv_layer_input_interface #(
  parameter int KERNEL_SIZE = 3,
  parameter int IMAGE_SIZE  = 8,
  parameter int ARRAY_SIZE  = 6,
  parameter int ADDR_WIDTH  = 6,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [1:0]                       input_interface_cmd,
  output logic [1:0]                       input_interface_ack,
  output logic                             rom_rd_en,
  output logic [ADDR_WIDTH-1:0]            rom_addr,
  input  logic [DATA_WIDTH-1:0]            rom_data,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] array_data,
  output logic                             array_valid
`ifdef CONV_IF_ERR_EN
  ,
  output logic                             cmd_err
`endif
);

  localparam int RW = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
  localparam int CW = $clog2(IMAGE_SIZE + 1);

  localparam logic [1:0] CMD_IDLE    = 2'd0;
  localparam logic [1:0] CMD_PRELOAD = 2'd1;
  localparam logic [1:0] CMD_SHIFT   = 2'd2;
  localparam logic [1:0] CMD_LOAD    = 2'd3;

  localparam logic [1:0] ACK_IDLE    = 2'd0;
  localparam logic [1:0] ACK_PRELOAD = 2'd1;
  localparam logic [1:0] ACK_SHIFT   = 2'd2;
  localparam logic [1:0] ACK_LOAD    = 2'd3;

  // The window must be exactly the number of valid kernel positions per row,
  // and a full image must fit in the ROM address space.
  if (IMAGE_SIZE - KERNEL_SIZE + 1 != ARRAY_SIZE) begin : g_bad_array
    $error("ARRAY_SIZE must equal IMAGE_SIZE-KERNEL_SIZE+1");
  end
  if (IMAGE_SIZE * IMAGE_SIZE > (1 << ADDR_WIDTH)) begin : g_bad_addr
    $error("IMAGE_SIZE^2 must fit in ADDR_WIDTH");
  end

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LAST} state_t;

  state_t                        state_q;
  logic [RW-1:0]                 row_ptr_q;
  logic [CW-1:0]                 col_q;       // column of the next address to issue
  logic [RW-1:0]                 pres_col_q;  // column of the address on rom_addr
  logic                          pend_vld_q;  // rom_data carries a word this cycle
  logic [RW-1:0]                 pend_idx_q;  // buffer slot for that word
  logic                          op_load_q;   // current fetch came from LOAD
  logic [DATA_WIDTH-1:0]         buf_q [IMAGE_SIZE];
  logic [1:0]                    ack_q;
  logic                          rom_rd_en_q;
  logic [ADDR_WIDTH-1:0]         rom_addr_q;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] array_data_q;
  logic                          array_valid_q;
`ifdef CONV_IF_ERR_EN
  logic                          cmd_err_q;
`endif

  logic [RW-1:0]         row_d;
  logic [CW-1:0]         col_d;
  logic [ADDR_WIDTH-1:0] addr_d;

  // Row/column of the next ROM address: a new row on PRELOAD/LOAD, otherwise
  // the running column of the current fetch. Product truncates to ADDR_WIDTH.
  always_comb begin
    row_d = row_ptr_q;
    col_d = col_q;
    if (state_q == S_IDLE) begin
      col_d = '0;
      if (input_interface_cmd == CMD_PRELOAD) begin
        row_d = '0;
      end else if (input_interface_cmd == CMD_LOAD) begin
        row_d = (row_ptr_q == RW'(IMAGE_SIZE - 1)) ? '0 : row_ptr_q + 1'b1;
      end
    end
    addr_d = ADDR_WIDTH'(ADDR_WIDTH'(row_d) * ADDR_WIDTH'(IMAGE_SIZE))
           + ADDR_WIDTH'(col_d);
  end

  // Command FSM, ROM fetch sequencing, row buffer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      row_ptr_q     <= '0;
      col_q         <= '0;
      pres_col_q    <= '0;
      pend_vld_q    <= 1'b0;
      pend_idx_q    <= '0;
      op_load_q     <= 1'b0;
      ack_q         <= ACK_IDLE;
      rom_rd_en_q   <= 1'b0;
      rom_addr_q    <= '0;
      array_data_q  <= '0;
      array_valid_q <= 1'b0;
      for (int i = 0; i < IMAGE_SIZE; i++) buf_q[i] <= '0;
`ifdef CONV_IF_ERR_EN
      cmd_err_q     <= 1'b0;
`endif
    end else begin
      ack_q         <= ACK_IDLE;
      array_valid_q <= 1'b0;

      // ROM answers one cycle after the strobe, so capture trails the address.
      if (pend_vld_q) buf_q[pend_idx_q] <= rom_data;
      pend_vld_q <= rom_rd_en_q;
      pend_idx_q <= pres_col_q;

      case (state_q)
        S_IDLE: begin
          case (input_interface_cmd)
            CMD_PRELOAD, CMD_LOAD: begin
              row_ptr_q   <= row_d;
              rom_rd_en_q <= 1'b1;
              rom_addr_q  <= addr_d;
              pres_col_q  <= '0;
              col_q       <= CW'(1);
              op_load_q   <= (input_interface_cmd == CMD_LOAD);
              state_q     <= S_FETCH;
            end
            CMD_SHIFT: begin
              for (int i = 0; i < ARRAY_SIZE; i++)
                array_data_q[i*DATA_WIDTH +: DATA_WIDTH] <= buf_q[i];
              for (int i = 0; i < IMAGE_SIZE; i++)
                buf_q[i] <= buf_q[(i + 1) % IMAGE_SIZE];
              array_valid_q <= 1'b1;
              ack_q         <= ACK_SHIFT;
            end
            default: ;
          endcase
        end
        S_FETCH: begin
`ifdef CONV_IF_ERR_EN
          if (input_interface_cmd != CMD_IDLE) cmd_err_q <= 1'b1;
`endif
          if (col_q == CW'(IMAGE_SIZE)) begin
            rom_rd_en_q <= 1'b0;
            state_q     <= S_LAST;
          end else begin
            rom_addr_q <= addr_d;
            pres_col_q <= RW'(col_q);
            col_q      <= col_q + 1'b1;
          end
        end
        S_LAST: begin
`ifdef CONV_IF_ERR_EN
          if (input_interface_cmd != CMD_IDLE) cmd_err_q <= 1'b1;
`endif
          ack_q   <= op_load_q ? ACK_LOAD : ACK_PRELOAD;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign input_interface_ack = ack_q;
  assign rom_rd_en           = rom_rd_en_q;
  assign rom_addr            = rom_addr_q;
  assign array_data          = array_data_q;
  assign array_valid         = array_valid_q;
`ifdef CONV_IF_ERR_EN
  assign cmd_err             = cmd_err_q;
`endif

endmodule

// File: tb/tb_conv_layer_input_interface.sv
// Bench for conv_layer_input_interface: fixed vector table for the PRELOAD /
// SHIFT / LOAD walk, hand sequences for reset and busy corner cases, and a
// randomized command run checked against a row/buffer reference model.
module tb_conv_layer_input_interface;
  localparam int IMG = 8;
  localparam int ARR = 6;
  localparam int DW  = 16;
  localparam int AW  = 6;
  localparam int WW  = ARR * DW;

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_PRE  = 2'd1;
  localparam logic [1:0] C_SHF  = 2'd2;
  localparam logic [1:0] C_LOAD = 2'd3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    cmd = 2'd0;
  logic [1:0]    ack;
  logic          rd_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] rom_data = '0;
  logic [WW-1:0] adata;
  logic          avalid;
`ifdef CONV_IF_ERR_EN
  logic          cmd_err;
`endif

  conv_layer_input_interface dut (
    .clk                 (clk),
    .rst                 (rst),
    .input_interface_cmd (cmd),
    .input_interface_ack (ack),
    .rom_rd_en           (rd_en),
    .rom_addr            (addr),
    .rom_data            (rom_data),
    .array_data          (adata),
    .array_valid         (avalid)
`ifdef CONV_IF_ERR_EN
    ,
    .cmd_err             (cmd_err)
`endif
  );

  always #5 clk = ~clk;

  // ROM model: word value equals its address, one cycle of latency.
  always @(posedge clk) if (rd_en) rom_data <= DW'(addr);

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: current row and buffer contents as plain integers.
  int            m_row;
  int            m_buf [IMG];
  logic [WW-1:0] m_win;

  task automatic model_reset();
    m_row = 0;
    for (int i = 0; i < IMG; i++) m_buf[i] = 0;
    m_win = '0;
  endtask

  task automatic model_apply(input logic [1:0] c, output logic [1:0] eack,
                             output int base, output logic [WW-1:0] ewin);
    int first;
    base = 0;
    eack = c;
    if (c == C_PRE || c == C_LOAD) begin
      m_row = (c == C_PRE) ? 0 : (m_row + 1) % IMG;
      for (int i = 0; i < IMG; i++) m_buf[i] = m_row * IMG + i;
      base = m_row * IMG;
    end else if (c == C_SHF) begin
      for (int i = 0; i < ARR; i++) m_win[i*DW +: DW] = DW'(m_buf[i]);
      first = m_buf[0];
      for (int i = 0; i < IMG - 1; i++) m_buf[i] = m_buf[i+1];
      m_buf[IMG-1] = first;
    end
    ewin = m_win;
  endtask

  function automatic logic [WW-1:0] mkwin(int start, int rowbase);
    logic [WW-1:0] w = '0;
    for (int i = 0; i < ARR; i++) w[i*DW +: DW] = DW'(rowbase + (start + i) % IMG);
    return w;
  endfunction

  // Drive one command pulse and check its full response with exact timing.
  task automatic exec_cmd(input logic [1:0] c, input logic [1:0] eack,
                          input int base, input logic [WW-1:0] ewin);
    @(negedge clk) cmd = c;
    @(negedge clk) cmd = C_IDLE;
    if (c == C_SHF) begin
      chk("shift_ack", 128'(ack), 128'(eack));
      chk("shift_valid", 128'(avalid), 128'(1));
      chk("shift_window", 128'(adata), 128'(ewin));
      @(negedge clk);
      chk("shift_ack_drop", 128'(ack), 128'(0));
      chk("shift_valid_drop", 128'(avalid), 128'(0));
      chk("window_hold", 128'(adata), 128'(ewin));
    end else begin
      for (int k = 0; k < IMG; k++) begin
        if (k > 0) @(negedge clk);
        chk("fetch_rden", 128'(rd_en), 128'(1));
        chk("fetch_addr", 128'(addr), 128'(base + k));
        chk("fetch_ack_quiet", 128'(ack), 128'(0));
      end
      @(negedge clk);
      chk("fetch_rden_off", 128'(rd_en), 128'(0));
      chk("fetch_ack_early", 128'(ack), 128'(0));
      @(negedge clk);
      chk("fetch_ack", 128'(ack), 128'(eack));
      chk("fetch_no_valid", 128'(avalid), 128'(0));
    end
  endtask

  typedef struct {
    logic [1:0]    cmd;
    logic [1:0]    ack;
    int            base;
    logic [WW-1:0] win;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkvec(logic [1:0] c, logic [1:0] a, int b, logic [WW-1:0] w);
    vec_t v;
    v.cmd = c; v.ack = a; v.base = b; v.win = w;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]    ea;
    int            eb;
    logic [WW-1:0] ew;
    logic [WW-1:0] wq [3];
    int            nack, nval, lastack, bad;

    // Expected responses written directly from the command definitions.
    tbl.push_back(mkvec(C_PRE,  2'd1, 0,  '0));
    tbl.push_back(mkvec(C_SHF,  2'd2, 0,  mkwin(0, 0)));
    tbl.push_back(mkvec(C_SHF,  2'd2, 0,  mkwin(1, 0)));
    tbl.push_back(mkvec(C_SHF,  2'd2, 0,  mkwin(2, 0)));
    tbl.push_back(mkvec(C_SHF,  2'd2, 0,  mkwin(3, 0)));
    tbl.push_back(mkvec(C_LOAD, 2'd3, 8,  '0));
    tbl.push_back(mkvec(C_SHF,  2'd2, 0,  mkwin(0, 8)));
    for (int r = 2; r < IMG; r++) tbl.push_back(mkvec(C_LOAD, 2'd3, r * IMG, '0));
    tbl.push_back(mkvec(C_LOAD, 2'd3, 0,  '0));
    tbl.push_back(mkvec(C_SHF,  2'd2, 0,  mkwin(0, 0)));

    // Reset held three cycles: everything quiet.
    repeat (3) @(negedge clk);
    chk("rst_ack", 128'(ack), 128'(0));
    chk("rst_rden", 128'(rd_en), 128'(0));
    chk("rst_addr", 128'(addr), 128'(0));
    chk("rst_data", 128'(adata), 128'(0));
    chk("rst_valid", 128'(avalid), 128'(0));
`ifdef CONV_IF_ERR_EN
    chk("rst_cmd_err", 128'(cmd_err), 128'(0));
`endif
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_rden", 128'(rd_en), 128'(0));
    end

    // Table walk: preload, shifts with wraparound, loads through row wrap.
    foreach (tbl[i]) begin
      model_apply(tbl[i].cmd, ea, eb, ew);
      exec_cmd(tbl[i].cmd, tbl[i].ack, tbl[i].base, tbl[i].win);
    end

    // Back-to-back SHIFTs, one per cycle.
    for (int j = 0; j < 3; j++) model_apply(C_SHF, ea, eb, wq[j]);
    @(negedge clk) cmd = C_SHF;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk) cmd = (j < 2) ? C_SHF : C_IDLE;
      chk("b2b_ack", 128'(ack), 128'(2));
      chk("b2b_valid", 128'(avalid), 128'(1));
      chk("b2b_window", 128'(adata), 128'(wq[j]));
    end
    @(negedge clk);
    chk("b2b_ack_drop", 128'(ack), 128'(0));
    chk("b2b_valid_drop", 128'(avalid), 128'(0));

    // SHIFT during a fetch is dropped.
    model_apply(C_PRE, ea, eb, ew);
    @(negedge clk) cmd = C_PRE;
    @(negedge clk) cmd = C_IDLE;
    @(negedge clk);
    @(negedge clk) cmd = C_SHF;
    @(negedge clk) cmd = C_IDLE;
    nack = 0; nval = 0; lastack = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ack != 2'd0) begin nack++; lastack = int'(ack); end
      if (avalid) nval++;
    end
    chk("busy_ack_count", 128'(nack), 128'(1));
    chk("busy_ack_value", 128'(lastack), 128'(1));
    chk("busy_no_valid", 128'(nval), 128'(0));
`ifdef CONV_IF_ERR_EN
    chk("busy_cmd_err", 128'(cmd_err), 128'(1));
`endif
    model_apply(C_SHF, ea, eb, ew);
    exec_cmd(C_SHF, ea, eb, ew);

    // Reset in the fourth fetch cycle aborts the fetch with no ack.
    @(negedge clk) cmd = C_LOAD;
    @(negedge clk) cmd = C_IDLE;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("abort_rden", 128'(rd_en), 128'(0));
    chk("abort_data_clr", 128'(adata), 128'(0));
`ifdef CONV_IF_ERR_EN
    chk("abort_cmd_err_clr", 128'(cmd_err), 128'(0));
`endif
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ack != 2'd0 || rd_en) bad++;
    end
    chk("abort_quiet", 128'(bad), 128'(0));
    model_reset();
    model_apply(C_SHF, ea, eb, ew);
    exec_cmd(C_SHF, ea, eb, ew);
    model_apply(C_LOAD, ea, eb, ew);
    exec_cmd(C_LOAD, ea, eb, ew);
    model_apply(C_PRE, ea, eb, ew);
    exec_cmd(C_PRE, ea, eb, ew);
    model_apply(C_SHF, ea, eb, ew);
    exec_cmd(C_SHF, ea, eb, ew);

    // Randomized command stream against the model.
    for (int n = 0; n < 40; n++) begin
      logic [1:0] c;
      int r;
      r = int'($urandom_range(0, 3));
      c = (r < 2) ? C_SHF : ((r == 2) ? C_LOAD : C_PRE);
      model_apply(c, ea, eb, ew);
      exec_cmd(c, ea, eb, ew);
      r = int'($urandom_range(0, 2));
      for (int g = 0; g < r; g++) begin
        @(negedge clk);
        chk("gap_ack", 128'(ack), 128'(0));
        chk("gap_valid", 128'(avalid), 128'(0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
